// File: rtl/fft_sample_buffer.sv
// fft_sample_buffer: ping-pong frame buffer; one bank fills from the sample stream while
// fft_controller reads the other, with frames dropped while the read bank is still claimed.
module fft_sample_buffer #(
    parameter int FFT_POINTS      = 512,
    parameter int DATA_WIDTH      = 24,
    parameter int LOG2_FFT_POINTS = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_sample_valid,
    input  logic [DATA_WIDTH-1:0]      i_sample,
    output logic                       o_data_ready,
    input  logic                       i_fft_busy,
    input  logic [LOG2_FFT_POINTS-1:0] i_read_addr,
    output logic [DATA_WIDTH-1:0]      o_read_data,
    output logic [LOG2_FFT_POINTS-1:0] o_fill_level,
    output logic                       o_overflow,
    output logic [7:0]                 o_drop_count
);
    localparam logic [1:0] S_FILL    = 2'd0;
    localparam logic [1:0] S_HANDOFF = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    logic [1:0]                 state;
    logic [1:0]                 state_next;
    logic                       wr_bank;
    logic [LOG2_FFT_POINTS-1:0] wr_ptr;
    logic [DATA_WIDTH-1:0]      mem [0:2*FFT_POINTS-1];
    logic                       complete;
    logic                       unlocked;
    logic                       swap;
    logic                       drop;

    assign complete = i_sample_valid && (wr_ptr == LOG2_FFT_POINTS'(FFT_POINTS - 1));
    // a release arriving with the last sample frees the read bank in time for this frame
    assign unlocked = (state == S_FILL) || (state == S_LOCKED && !i_fft_busy);
    assign swap     = complete && unlocked;
    assign drop     = complete && !unlocked;

    always_comb begin
        state_next = swap                                ? S_HANDOFF :
                     (state == S_HANDOFF &&  i_fft_busy) ? S_LOCKED  :
                     (state == S_LOCKED  && !i_fft_busy) ? S_FILL    :
                     (state == S_HANDOFF || state == S_LOCKED) ? state : S_FILL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_FILL;
            wr_bank      <= 1'b0;
            wr_ptr       <= '0;
            o_data_ready <= 1'b0;
            o_overflow   <= 1'b0;
            o_drop_count <= 8'd0;
        end else begin
            state        <= state_next;
            wr_bank      <= swap ? ~wr_bank : wr_bank;
            wr_ptr       <= i_sample_valid ? wr_ptr + 1'b1 : wr_ptr;
            o_data_ready <= swap;
            o_overflow   <= drop;
            o_drop_count <= (drop && o_drop_count != 8'hff) ? o_drop_count + 8'd1 : o_drop_count;
        end
    end

    // storage is deliberately left out of reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (i_sample_valid && !reset)
            mem[{wr_bank, wr_ptr}] <= i_sample;
    end

    assign o_read_data  = mem[{~wr_bank, i_read_addr}];
    assign o_fill_level = wr_ptr;
endmodule

// File: tb/tb_fft_sample_buffer.sv
// tb_fft_sample_buffer: randomized and directed stimulus for fft_sample_buffer, checked
// against a frame-level model of bank ownership kept in the bench.
module tb_fft_sample_buffer;
    localparam int N = 512;
    localparam int W = 24;
    localparam int L = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid = 1'b0;
    logic [W-1:0] sample = '0;
    logic         busy = 1'b0;
    logic [L-1:0] raddr = '0;
    logic         o_data_ready;
    logic [W-1:0] o_read_data;
    logic [L-1:0] o_fill_level;
    logic         o_overflow;
    logic [7:0]   o_drop_count;

    fft_sample_buffer #(.FFT_POINTS(N), .DATA_WIDTH(W), .LOG2_FFT_POINTS(L)) dut (
        .clk(clk), .reset(reset), .i_sample_valid(valid), .i_sample(sample),
        .o_data_ready(o_data_ready), .i_fft_busy(busy), .i_read_addr(raddr),
        .o_read_data(o_read_data), .o_fill_level(o_fill_level),
        .o_overflow(o_overflow), .o_drop_count(o_drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int bad_cycles = 0;
    int rdy_pulses = 0;
    int ovf_pulses = 0;

    // model: which bank is being filled, and whether the controller still owns the other
    logic [W-1:0] m_bank [2][N];
    int m_wb = 0, m_ptr = 0, m_drops = 0;
    bit m_held = 0, m_started = 0, e_rdy = 0, e_ovf = 0;

    task automatic tick(input bit r, input bit v, input logic [W-1:0] s, input bit b);
        bit free;
        @(negedge clk);
        reset = r; valid = v; sample = s; busy = b;
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_wb = 0; m_held = 0; m_started = 0; e_rdy = 0; e_ovf = 0; m_drops = 0;
        end else begin
            free = !m_held || (m_started && !b);
            e_rdy = 0;
            e_ovf = 0;
            if (m_held && !m_started && b) m_started = 1;
            else if (m_held && m_started && !b) begin m_held = 0; m_started = 0; end
            if (v) begin
                m_bank[m_wb][m_ptr] = s;
                if (m_ptr == N - 1) begin
                    if (free) begin m_wb = 1 - m_wb; m_held = 1; m_started = 0; e_rdy = 1; end
                    else begin e_ovf = 1; if (m_drops < 255) m_drops++; end
                end
                m_ptr = (m_ptr + 1) % N;
            end
        end
        #1;
        if (o_data_ready !== e_rdy || o_overflow !== e_ovf || o_drop_count !== 8'(m_drops) ||
            o_fill_level !== L'(m_ptr))
            bad_cycles++;
        rdy_pulses += int'(o_data_ready);
        ovf_pulses += int'(o_overflow);
    endtask

    task automatic test_reset;
        bad_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1, 1, W'($urandom), 0);
            checks++; if (o_fill_level !== 0) begin errors++; $display("FAIL reset_fill got %0d want 0", o_fill_level); end
            checks++; if (o_data_ready !== 0) begin errors++; $display("FAIL reset_ready got %b want 0", o_data_ready); end
            checks++; if (o_drop_count !== 0) begin errors++; $display("FAIL reset_drops got %0d want 0", o_drop_count); end
        end
        tick(0, 1, 1, 0);
        checks++; if (o_fill_level !== 1) begin errors++; $display("FAIL first_sample_fill got %0d want 1", o_fill_level); end
        checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL reset_model got %0d bad cycles want 0", bad_cycles); end
    endtask

    task automatic test_full_frame;
        bad_cycles = 0; rdy_pulses = 0;
        for (int v = 2; v < N; v++) tick(0, 1, W'(v), 0);
        checks++; if (o_data_ready !== 0) begin errors++; $display("FAIL early_ready got %b want 0", o_data_ready); end
        tick(0, 1, W'(N), 0);
        checks++; if (o_data_ready !== 1) begin errors++; $display("FAIL ready_latency got %b want 1", o_data_ready); end
        checks++; if (o_fill_level !== 0) begin errors++; $display("FAIL fill_after_swap got %0d want 0", o_fill_level); end
        tick(0, 0, 0, 0);
        checks++; if (o_data_ready !== 0) begin errors++; $display("FAIL ready_width got %b want 0", o_data_ready); end
        for (int k = 0; k < N; k++) begin
            tick(0, 0, 0, 0);
            raddr = L'(k);
            #1;
            checks++; if (o_read_data !== W'(k + 1)) begin errors++; $display("FAIL frame1_read[%0d] got %0d want %0d", k, o_read_data, k + 1); end
        end
        checks++; if (rdy_pulses !== 1) begin errors++; $display("FAIL frame1_pulses got %0d want 1", rdy_pulses); end
        checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL frame1_model got %0d bad cycles want 0", bad_cycles); end
    endtask

    task automatic test_overflow;
        bad_cycles = 0; rdy_pulses = 0; ovf_pulses = 0;
        for (int i = 0; i < N; i++) tick(0, 1, W'(1001 + i), 1);
        checks++; if (o_overflow !== 1) begin errors++; $display("FAIL overflow_pulse got %b want 1", o_overflow); end
        checks++; if (o_drop_count !== 1) begin errors++; $display("FAIL drop_count got %0d want 1", o_drop_count); end
        for (int k = 0; k < N; k += 7) begin
            tick(0, 0, 0, 1);
            raddr = L'(k);
            #1;
            checks++; if (o_read_data !== W'(k + 1)) begin errors++; $display("FAIL held_read[%0d] got %0d want %0d", k, o_read_data, k + 1); end
        end
        checks++; if (rdy_pulses !== 0 || ovf_pulses !== 1) begin errors++; $display("FAIL overflow_pulses got ready=%0d ovf=%0d want 0 1", rdy_pulses, ovf_pulses); end
        checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL overflow_model got %0d bad cycles want 0", bad_cycles); end
    endtask

    task automatic test_unlock_same_cycle;
        bad_cycles = 0;
        for (int i = 0; i < N - 1; i++) tick(0, 1, W'(2001 + i), 1);
        tick(0, 1, W'(2512), 0);
        checks++; if (o_data_ready !== 1 || o_overflow !== 0) begin errors++; $display("FAIL unlock_handoff got ready=%b ovf=%b want 1 0", o_data_ready, o_overflow); end
        tick(0, 0, 0, 0);
        raddr = 0;
        #1;
        checks++; if (o_read_data !== W'(2001)) begin errors++; $display("FAIL unlock_read0 got %0d want 2001", o_read_data); end
        raddr = L'(N - 1);
        #1;
        checks++; if (o_read_data !== W'(2512)) begin errors++; $display("FAIL unlock_read511 got %0d want 2512", o_read_data); end
        checks++; if (o_drop_count !== 1) begin errors++; $display("FAIL unlock_drops got %0d want 1", o_drop_count); end
        checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL unlock_model got %0d bad cycles want 0", bad_cycles); end
    endtask

    task automatic test_sparse;
        bad_cycles = 0;
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        rdy_pulses = 0;
        for (int i = 0; i < N; i++) begin
            tick(0, 0, 0, 0);
            tick(0, 0, 0, 0);
            tick(0, 1, W'(3001 + i), 0);
            if (i == 99) begin
                checks++; if (o_fill_level !== 100) begin errors++; $display("FAIL sparse_fill got %0d want 100", o_fill_level); end
            end
        end
        checks++; if (o_data_ready !== 1) begin errors++; $display("FAIL sparse_ready got %b want 1", o_data_ready); end
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        raddr = 0;
        #1;
        checks++; if (o_read_data !== W'(3001)) begin errors++; $display("FAIL sparse_read0 got %0d want 3001", o_read_data); end
        checks++; if (rdy_pulses !== 1) begin errors++; $display("FAIL sparse_pulses got %0d want 1", rdy_pulses); end
        checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL sparse_model got %0d bad cycles want 0", bad_cycles); end
    endtask

    task automatic test_reset_locked;
        bad_cycles = 0;
        tick(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) tick(0, 1, W'($urandom), 1);
        checks++; if (o_fill_level !== 300) begin errors++; $display("FAIL locked_fill got %0d want 300", o_fill_level); end
        tick(1, 0, 0, 1);
        checks++; if (o_fill_level !== 0 || o_drop_count !== 0) begin errors++; $display("FAIL locked_reset got fill=%0d drops=%0d want 0 0", o_fill_level, o_drop_count); end
        rdy_pulses = 0; ovf_pulses = 0;
        for (int i = 0; i < N; i++) tick(0, 1, W'($urandom), 0);
        tick(0, 0, 0, 0);
        checks++; if (rdy_pulses !== 1 || ovf_pulses !== 0) begin errors++; $display("FAIL post_reset_pulses got ready=%0d ovf=%0d want 1 0", rdy_pulses, ovf_pulses); end
        checks++; if (o_drop_count !== 0) begin errors++; $display("FAIL post_reset_drops got %0d want 0", o_drop_count); end
        for (int i = 0; i < 16; i++) begin
            tick(0, 0, 0, 0);
            raddr = L'($urandom);
            #1;
            checks++; if (o_read_data !== m_bank[1 - m_wb][raddr]) begin errors++; $display("FAIL post_reset_read[%0d] got %0d want %0d", raddr, o_read_data, m_bank[1 - m_wb][raddr]); end
        end
        checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL locked_model got %0d bad cycles want 0", bad_cycles); end
    endtask

    task automatic test_random;
        bit b = 0;
        bad_cycles = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 99) < 4) b = ~b;
            tick(0, $urandom_range(0, 3) != 0, W'($urandom), b);
        end
        for (int i = 0; i < 32; i++) begin
            tick(0, 0, 0, b);
            raddr = L'($urandom);
            #1;
            checks++; if (o_read_data !== m_bank[1 - m_wb][raddr]) begin errors++; $display("FAIL random_read[%0d] got %0d want %0d", raddr, o_read_data, m_bank[1 - m_wb][raddr]); end
        end
        checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL random_model got %0d bad cycles want 0", bad_cycles); end
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_overflow;
        test_unlock_same_cycle;
        test_sparse;
        test_reset_locked;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_sample_buffer.md
Name: fft_sample_buffer

Overview:
- Ping-pong sample buffer that feeds fft_controller; it answers the controller's buffer-read interface.
- Accepts a stream of DATA_WIDTH-bit audio samples and fills one bank while the controller reads the other.
- Pulses o_data_ready when a full FFT_POINTS frame is ready.
- Holds that frame stable until the controller's busy cycle ends.

Parameters:
FFT_POINTS, 512, samples per frame; must be a power of 2
DATA_WIDTH, 24, sample width in bits
LOG2_FFT_POINTS, 9, address width; equals log2(FFT_POINTS)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
i_sample_valid  input  1  qualifies i_sample; may be high every cycle
i_sample  input  DATA_WIDTH  incoming audio sample
o_data_ready  output  1  one-cycle pulse: read bank holds a complete frame; drives controller i_data_ready
i_fft_busy  input  1  controller busy flag
i_read_addr  input  LOG2_FFT_POINTS  controller buffer read address
o_read_data  output  DATA_WIDTH  read-bank word at i_read_addr; combinational read
o_fill_level  output  LOG2_FFT_POINTS  samples written into the current write bank
o_overflow  output  1  one-cycle pulse: a completed frame was discarded
o_drop_count  output  8  frames discarded since reset; saturates at 255

Behaviour:
- Storage: two banks of FFT_POINTS x DATA_WIDTH.
- wr_bank is a 1-bit register. The read bank is ~wr_bank.
- o_read_data = bank[~wr_bank][i_read_addr]. It is combinational, with the same-cycle address-to-data path the controller requires.
- Write: on i_sample_valid, bank[wr_bank][wr_ptr] <= i_sample, and wr_ptr increments. o_fill_level = wr_ptr.
- FSM states:
  - S_FILL: read bank free.
  - S_HANDOFF: o_data_ready issued; waiting for i_fft_busy=1.
  - S_LOCKED: controller processing; waiting for i_fft_busy=0.
- Transitions:
  - S_HANDOFF -> S_LOCKED when i_fft_busy=1.
  - S_LOCKED -> S_FILL when i_fft_busy=0.
  - While in S_HANDOFF or S_LOCKED, the read bank and wr_bank must not change.
- Frame completion event: a write with i_sample_valid=1 and wr_ptr=FFT_POINTS-1. wr_ptr wraps to 0 in every case.
- Unlocked completion (state S_FILL, or S_LOCKED with i_fft_busy=0 in the same cycle):
  - wr_bank toggles and the state goes to S_HANDOFF.
  - o_data_ready=1 on the following cycle only; it is a registered pulse.
  - Latency from the last-sample write edge to o_data_ready high is 1 cycle.
- Locked completion (S_HANDOFF, or S_LOCKED with i_fft_busy=1):
  - Frame discarded; wr_bank unchanged; the write bank is overwritten by the next frame.
  - o_overflow pulses 1 cycle, on the same timing as o_data_ready.
  - o_drop_count increments, saturating at 255.
- Simultaneous unlock and completion: the unlock takes effect first, so the frame is handed off, not dropped.
- Samples arriving the cycle after a swap go to the new write bank at address 0. No sample is lost across a swap.
- i_sample_valid gaps of any length are allowed. wr_ptr holds during gaps.
- Reset (synchronous, any state, mid-frame included):
  - wr_ptr=0, wr_bank=0, state=S_FILL.
  - o_data_ready=0, o_overflow=0, o_drop_count=0; o_fill_level reads 0.
  - Bank contents are not cleared. o_read_data is undefined until the first handoff.
- i_read_addr is ignored for state purposes. Reads in any state are side-effect free.

Test Plan:
1. Reset held 5 cycles with i_sample_valid=1 -> o_fill_level=0, o_data_ready=0, o_drop_count=0 throughout; first sample after release lands at address 0.
2. 512 back-to-back samples valued 1..512, then read addresses 0..511 -> o_data_ready single pulse 1 cycle after sample 512; o_read_data(k)=k+1; o_fill_level=0 after the swap.
3. After handoff, assert i_fft_busy and stream 512 further samples (1001..1512) -> o_overflow pulse, o_drop_count=1, no o_data_ready; read data still k+1.
4. Deassert i_fft_busy in the same cycle sample 512 of frame 3 (2001..2512) is written -> o_data_ready pulse, no overflow; o_read_data(0)=2001.
5. Sparse input, valid every 3rd cycle, 512 samples -> exactly one o_data_ready pulse, 1 cycle after the 512th valid; fill level tracks the valid count.
6. Reset asserted at fill level 300 during S_LOCKED -> next 512 samples produce an o_data_ready pulse with no overflow; o_drop_count=0.
